// File: rtl/universal_shift_register.sv
// Parameterised universal shift register: hold, shift right/left, parallel load,
// synchronous preset, and a saturating count of shifts since the last load/preset.
module universal_shift_register #(
    parameter int WIDTH = 4,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qnot,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    mode_e mode_sel;
    assign mode_sel = mode_e'(mode);

    // Preset outranks every mode; shifts in either direction share one saturating count.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q   <= '0;
            cnt <= '0;
        end else if (pre) begin
            q   <= '1;
            cnt <= '0;
        end else begin
            case (mode_sel)
                MODE_HOLD: begin
                    q   <= q;
                    cnt <= cnt;
                end
                MODE_SHR: begin
                    q <= {sin_r, q[WIDTH-1:1]};
                    if (cnt < FULL)
                        cnt <= cnt + CW'(1);
                end
                MODE_SHL: begin
                    q <= {q[WIDTH-2:0], sin_l};
                    if (cnt < FULL)
                        cnt <= cnt + CW'(1);
                end
                MODE_LOAD: begin
                    q   <= pin;
                    cnt <= '0;
                end
                default: begin
                    q   <= q;
                    cnt <= cnt;
                end
            endcase
        end
    end

    assign qnot   = ~q;
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];
    assign done   = (cnt == FULL);

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parameterised universal shift register built as the stage directly downstream of the single-bit D flip-flop.
- Consumes serial bits, such as the flip-flop's q, on either end of the register.
- Also supports parallel load, hold, and a synchronous preset.
- A shift counter flags when a full word has been shifted in since the last load. Used for serial-to-parallel and parallel-to-serial conversion in lab datapaths.

Parameters:
- WIDTH, 4, register width in bits (legal range 2 to 16).
- CW, 5, counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-low reset.
- pre  input  1  synchronous preset, active-high.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  input  1  serial input entering at the MSB on shift right.
- sin_l  input  1  serial input entering at the LSB on shift left.
- pin  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- qnot  output  WIDTH  bitwise complement of q, always equal to ~q.
- sout_r  output  1  equals q[0], the bit leaving on shift right.
- sout_l  output  1  equals q[WIDTH-1], the bit leaving on shift left.
- cnt  output  CW  shifts since the last load or preset; saturates at WIDTH.
- done  output  1  high when cnt == WIDTH.

Behaviour:
- Reset
  - While clr=0, independent of clk: q=0, qnot=all ones, cnt=0, done=0.
  - Once clr returns high, the first rising edge applies normal operation.
  - Asserting clr mid-shift aborts the sequence immediately; no partial state is retained.
- Priority at each rising edge with clr=1: pre first, then mode.
- pre=1
  - q = all ones, cnt = 0, done = 0.
  - mode, sin_r, sin_l and pin are ignored that cycle.
- mode=00: q and cnt unchanged.
- mode=01 (shift right)
  - q <= {sin_r, q[WIDTH-1:1]}.
  - cnt <= cnt+1 if cnt < WIDTH, else it holds.
- mode=10 (shift left)
  - q <= {q[WIDTH-2:0], sin_l}.
  - cnt increments and saturates exactly as for shift right.
- mode=11: q <= pin, cnt <= 0.
- Counter
  - Shift direction does not affect cnt; mixed left and right shifts all count.
  - cnt never exceeds WIDTH and never wraps.
- Output timing
  - All outputs are registered or derived combinationally from registered state: qnot, sout_r, sout_l and done.
  - Latency from input to q is one clock edge.
  - sout_r and sout_l show the bit that leaves on the next shift, before that edge.
- Boundaries
  - Back-to-back opposite shifts are legal; each edge uses the q value present before that edge.
  - Load in the same cycle that done=1 clears done on that edge.
  - Unknown (X) mode is not supported; behaviour is undefined.
- Implementation: single clocked always block with the asynchronous clr in the sensitivity list; no latches, no gated clocks.

Test Plan:
- Reset: clr=0 with random inputs, toggling clk -> q=0000, qnot=1111, cnt=0, done=0. Drop clr between clock edges -> outputs change immediately, with no wait for an edge.
- Load then hold: mode=11, pin=1011 -> q=1011, qnot=0100, sout_r=1, sout_l=1, cnt=0. mode=00 for 3 edges -> no change.
- Serial-in right: from q=0000, mode=01 with sin_r=1,0,1,1 on successive edges -> q=1000, 0100, 1010, then 1101. cnt=1,2,3,4 and done=1 after the 4th edge. A 5th shift with sin_r=0 -> q=0110, cnt stays 4.
- Serial-out left: load 1001, then mode=10 with sin_l=0 for 4 edges -> sout_l sequence 1,0,0,1 sampled before each edge; final q=0000, done=1.
- Priority: pre=1 together with mode=11, pin=0000 -> q=1111, cnt=0. pre=1 together with a shift while cnt=3 -> q=1111, cnt=0.
- Reset mid-operation: after 2 shifts, pulse clr low for 3 ns between edges -> q=0, cnt=0 immediately. The next shift after release gives cnt=1.
